// File: rtl/matmul_bus_master_if.sv
// Register-file bus between the matmul bus master and the register-file slave.
// Writes are single-cycle (we high for one cycle). Reads are combinational:
// the responder returns rdata for the address driven in the same cycle.
interface matmul_bus_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int MAX_DIM    = 2
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [BUS_WIDTH-1:0]  wdata;
  logic                  we;
  logic [MAX_DIM-1:0]    strobe;
  logic [BUS_WIDTH-1:0]  rdata;

  modport master (output addr, wdata, we, strobe, input rdata);
  modport slave  (input addr, wdata, we, strobe, output rdata);
endinterface

// File: rtl/matmul_bus_master.sv
// Bus initiator for the matmul register file. It takes one job descriptor,
// streams A then B operand rows, writes CONTROL with start set, polls until
// start clears (or times out), then reads N result rows and the FLAGS word.
module matmul_bus_master #(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int POLL_LIMIT = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // job descriptor
  input  logic                 job_valid_i,
  output logic                 job_ready_o,
  input  logic [1:0]           job_n_i,
  input  logic [1:0]           job_k_i,
  input  logic [1:0]           job_m_i,
  input  logic                 job_mode_i,
  input  logic [1:0]           job_wtgt_i,
  input  logic [1:0]           job_rtgt_i,
  // operand row stream
  input  logic                 op_valid_i,
  output logic                 op_ready_o,
  input  logic [BUS_WIDTH-1:0] op_data_i,
  // register-file bus
  matmul_bus_master_if.master  bus,
  // result stream and status
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [BUS_WIDTH-1:0] res_data_o,
  output logic                 res_last_o,
  output logic [BUS_WIDTH-1:0] flags_o,
  output logic                 done_o,
  output logic                 timeout_o
);
  localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
  localparam int RW      = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
  localparam int PW      = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;

  localparam logic [4:0] A_CONTROL = 5'h00;
  localparam logic [4:0] A_OPA     = 5'h04;
  localparam logic [4:0] A_OPB     = 5'h08;
  localparam logic [4:0] A_FLAGS   = 5'h0C;
  localparam logic [4:0] A_SP      = 5'h10;

  typedef struct packed {
    logic       mode;
    logic [1:0] wtgt;
    logic [1:0] rtgt;
    logic [1:0] n;
    logic [1:0] k;
    logic [1:0] m;
  } job_t;

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, WR_CTRL, POLL, RD_SP, RD_FLAGS, DONE
  } state_t;

  state_t        st, nxt;
  job_t          job;
  logic [1:0]    row;
  logic [PW-1:0] poll_cnt;
  logic [15:0]   ctrl_word;
  logic          poll_busy;
  logic          poll_expired;

  // Register address: base in [4:0], row index just above it.
  function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [4:0] base, input logic [1:0] r);
    reg_addr = ADDR_WIDTH'(base) | (ADDR_WIDTH'(r[RW-1:0]) << 5);
  endfunction

  assign ctrl_word    = {2'b00, job.m, job.k, job.n, 2'b00, job.rtgt, job.wtgt, job.mode, 1'b1};
  assign poll_busy    = bus.rdata[0];
  assign poll_expired = (poll_cnt == PW'(POLL_LIMIT - 1));

  // State register; reset drops straight to IDLE so no write can follow it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) st <= IDLE;
    else       st <= nxt;
  end

  // Next state and bus/handshake outputs; every bus output idles at zero.
  always_comb begin
    nxt         = st;
    job_ready_o = 1'b0;
    op_ready_o  = 1'b0;
    done_o      = 1'b0;
    bus.addr    = '0;
    bus.wdata   = '0;
    bus.we      = 1'b0;
    bus.strobe  = '0;
    unique case (st)
      IDLE: begin
        job_ready_o = 1'b1;
        if (job_valid_i) nxt = WR_A;
      end
      WR_A, WR_B: begin
        op_ready_o = 1'b1;
        if (op_valid_i) begin
          bus.we     = 1'b1;
          bus.addr   = reg_addr((st == WR_A) ? A_OPA : A_OPB, row);
          bus.wdata  = op_data_i;
          bus.strobe = '1;
          if (st == WR_A && row == job.n) nxt = WR_B;
          if (st == WR_B && row == job.k) nxt = WR_CTRL;
        end
      end
      WR_CTRL: begin
        bus.we     = 1'b1;
        bus.addr   = reg_addr(A_CONTROL, 2'd0);
        bus.wdata  = BUS_WIDTH'(ctrl_word);
        bus.strobe = '1;
        nxt        = POLL;
      end
      POLL: begin
        bus.addr = reg_addr(A_CONTROL, 2'd0);
        if (!poll_busy)        nxt = RD_SP;
        else if (poll_expired) nxt = DONE;
      end
      RD_SP: begin
        bus.addr = reg_addr(A_SP, row);
        if (res_valid_o && res_ready_i && res_last_o) nxt = RD_FLAGS;
      end
      RD_FLAGS: begin
        bus.addr = reg_addr(A_FLAGS, 2'd0);
        nxt      = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Descriptor latch, row/poll counters, result buffer and status capture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      job         <= '0;
      row         <= '0;
      poll_cnt    <= '0;
      res_valid_o <= 1'b0;
      res_last_o  <= 1'b0;
      res_data_o  <= '0;
      flags_o     <= '0;
      timeout_o   <= 1'b0;
    end else begin
      unique case (st)
        IDLE: if (job_valid_i) begin
          job       <= '{mode: job_mode_i, wtgt: job_wtgt_i, rtgt: job_rtgt_i,
                         n: job_n_i, k: job_k_i, m: job_m_i};
          row       <= '0;
          poll_cnt  <= '0;
          timeout_o <= 1'b0;
          flags_o   <= '0;
        end
        WR_A: if (op_valid_i) row <= (row == job.n) ? 2'd0 : row + 2'd1;
        WR_B: if (op_valid_i) row <= (row == job.k) ? 2'd0 : row + 2'd1;
        WR_CTRL: poll_cnt <= '0;
        POLL: begin
          if (!poll_busy) row <= '0;
          else begin
            poll_cnt <= poll_cnt + PW'(1);
            if (poll_expired) timeout_o <= 1'b1;
          end
        end
        RD_SP: begin
          // One-entry buffer: load when empty, advance row only on handshake.
          if (!res_valid_o) begin
            res_valid_o <= 1'b1;
            res_data_o  <= bus.rdata;
            res_last_o  <= (row == job.n);
          end else if (res_ready_i) begin
            res_valid_o <= 1'b0;
            res_last_o  <= 1'b0;
            row         <= row + 2'd1;
          end
        end
        RD_FLAGS: flags_o <= bus.rdata;
        default: ;
      endcase
    end
  end
endmodule
